// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage: fixed-latency busy counter, owns HI/LO.
// Optional feature macro: MD_DIV0_HOLD_EN (divide by zero leaves HI/LO unchanged).
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] md_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_hi_nxt, r_lo_nxt;
    logic        w_start, w_done;
    logic        w_is_long, w_is_div, w_idle_valid;

    logic [63:0] w_prod_s, w_prod_u;
    logic [31:0] w_a_mag, w_b_mag, w_b_u;
    logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr;
    logic [31:0] w_res_hi, w_res_lo;

    assign w_idle_valid = (r_state == IDLE) && md_valid;
    assign w_is_div     = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign w_is_long    = (md_op == OP_MULT) || (md_op == OP_MULTU) || w_is_div;

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000
    // deterministically; divisors of zero are replaced by 1 to keep X out of the datapath.
    assign w_a_mag  = a[31] ? (32'd0 - a) : a;
    assign w_b_mag  = b[31] ? (32'd0 - b) : ((b == 32'd0) ? 32'd1 : b);
    assign w_b_u    = (b == 32'd0) ? 32'd1 : b;
    assign w_sq_mag = w_a_mag / w_b_mag;
    assign w_sr_mag = w_a_mag % w_b_mag;
    assign w_sq     = (a[31] ^ b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr     = a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        if (w_is_div && (b == 32'd0)) begin
`ifdef MD_DIV0_HOLD_EN
            w_res_hi = r_hi;
            w_res_lo = r_lo;
`else
            w_res_hi = a;
            w_res_lo = 32'hFFFF_FFFF;
`endif
        end else begin
            case (md_op)
                OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
                OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
                OP_DIV:   begin w_res_hi = w_sr; w_res_lo = w_sq; end
                OP_DIVU:  begin w_res_hi = a % w_b_u; w_res_lo = a / w_b_u; end
                default:  ;
            endcase
        end
    end

    // NOTE: every signal written in this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (md_valid && w_is_long) begin
                    w_start     = 1'b1;
                    w_cnt_nxt   = w_is_div ? DIV_N : MULT_N;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: the pending result is reset too, so an aborted op can never leak into HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_nxt <= 32'd0;
            r_lo_nxt <= 32'd0;
        end else begin
            if (w_start) begin
                r_hi_nxt <= w_res_hi;
                r_lo_nxt <= w_res_lo;
            end
            if (w_done) begin
                r_hi <= r_hi_nxt;
                r_lo <= r_lo_nxt;
            end else if (w_idle_valid && (md_op == OP_MTHI)) begin
                r_hi <= a;
            end else if (w_idle_valid && (md_op == OP_MTLO)) begin
                r_lo <= a;
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign md_out = (md_op == OP_MFHI) ? r_hi :
                    (md_op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: a reference model pushes expected HI/LO and busy length
// into a scoreboard at issue; entries are popped and compared when busy drops.
module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        md_valid = 1'b0;
    logic [3:0]  md_op    = 4'd0;
    logic [31:0] a        = 32'd0;
    logic [31:0] b        = 32'd0;
    logic        busy;
    logic [31:0] md_out;

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .md_out   (md_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          n;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
        md_op = 4'd7;
        #1 check({tag, " HI"}, md_out, eh);
        md_op = 4'd8;
        #1 check({tag, " LO"}, md_out, el);
        md_op = 4'd0;
    endtask

    // Reference model: the architectural result of a long op, computed from the operands.
    task automatic model_push(input string tag, input logic [3:0] op,
                              input logic [31:0] x, input logic [31:0] y);
        longint      p;
        int          sx, sy;
        logic [31:0] hi, lo;
        int          n;
        sx = x;
        sy = y;
        n  = (op >= 4'd3) ? DIV_N : MULT_N;
        hi = 32'd0;
        lo = 32'd0;
        if (op == 4'd1) begin
            p  = longint'($signed(x)) * longint'($signed(y));
            hi = p[63:32];
            lo = p[31:0];
        end else if (op == 4'd2) begin
            p  = longint'({32'd0, x}) * longint'({32'd0, y});
            hi = p[63:32];
            lo = p[31:0];
        end else if (y == 32'd0) begin
`ifdef MD_DIV0_HOLD_EN
            hi = m_hi;
            lo = m_lo;
`else
            hi = x;
            lo = 32'hFFFF_FFFF;
`endif
        end else if (op == 4'd3) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                lo = 32'h8000_0000;
                hi = 32'd0;
            end else begin
                lo = sx / sy;
                hi = sx % sy;
            end
        end else begin
            lo = x / y;
            hi = x % y;
        end
        m_hi = hi;
        m_lo = lo;
        sb.push_back('{tag, n, hi, lo});
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        md_valid = 1'b1;
        md_op    = op;
        a        = x;
        b        = y;
        @(negedge clk);
        md_valid = 1'b0;
        md_op    = 4'd0;
    endtask

    task automatic issue_long(input string tag, input logic [3:0] op,
                              input logic [31:0] x, input logic [31:0] y);
        model_push(tag, op, x, y);
        issue(op, x, y);
    endtask

    // Counts busy cycles (operands scrambled meanwhile), then checks against the scoreboard.
    task automatic wait_done(input int already);
        int   cnt;
        exp_t e;
        cnt = already;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard: observed empty expected entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, " busy cycles"}, 32'(cnt), 32'(e.n));
            read_hilo(e.tag, e.hi, e.lo);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        read_hilo("reset", 32'd0, 32'd0);
        reset = 1'b0;

        issue_long("mult neg", 4'd1, 32'hFFFF_FFFD, 32'd5);
        wait_done(0);
        issue_long("multu", 4'd2, 32'hFFFF_FFFF, 32'd2);
        wait_done(0);
        issue_long("div neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(0);
        issue_long("divu", 4'd4, 32'hFFFF_FFF9, 32'd2);
        wait_done(0);
        issue_long("div ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0);
        issue_long("mult big", 4'd1, 32'h7FFF_FFFF, 32'h8000_0000);
        wait_done(0);

        // Ops presented while busy must be ignored.
        issue_long("mult ignore", 4'd1, 32'd3, 32'd4);
        check("busy c1", 32'(busy), 32'd1);
        md_valid = 1'b1; md_op = 4'd6; a = 32'h55;
        @(negedge clk);
        check("busy c2", 32'(busy), 32'd1);
        md_op = 4'd4; a = 32'd9; b = 32'd3;
        @(negedge clk);
        md_valid = 1'b0; md_op = 4'd0;
        wait_done(2);

        issue(4'd5, 32'h11, 32'd0);
        m_hi = 32'h11;
        check("mthi busy", 32'(busy), 32'd0);
        issue(4'd6, 32'h22, 32'd0);
        m_lo = 32'h22;
        read_hilo("mthi mtlo", 32'h11, 32'h22);
        issue_long("div by zero", 4'd3, 32'd7, 32'd0);
        wait_done(0);
        issue_long("divu by zero", 4'd4, 32'hABCD_0123, 32'd0);
        wait_done(0);

        issue(4'd9, 32'h1234, 32'h5678);
        check("op9 busy", 32'(busy), 32'd0);
        read_hilo("op9", m_hi, m_lo);

        // Asynchronous reset in busy cycle 4 aborts the divide.
        issue(4'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("pre-reset busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        #1 check("abort busy", 32'(busy), 32'd0);
        read_hilo("abort", 32'd0, 32'd0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("post-abort busy", 32'(busy), 32'd0);
        read_hilo("post-abort", 32'd0, 32'd0);

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
